// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// loads the IF/ID pipeline register, honouring stall/flush and ID-issued redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        addr_err,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] seq_pc;
    logic        misaligned;
    logic        range_err;

    assign seq_pc    = pc_q + 32'd4;
    assign redirect  = jr_en | j_en | br_taken;
    assign range_err = (pc_q > LAST_ADDR);

    // The jump region comes from the latched PC+4 of the jump sitting in ID.
    always_comb begin
        if (jr_en) begin
            target_raw = jr_target;
        end else if (j_en) begin
            target_raw = {pc4_q[31:28], j_index, 2'b00};
        end else begin
            target_raw = br_target;
        end
    end

    assign misaligned = redirect && (target_raw[1:0] != 2'b00);

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (!stall) begin
            pc_d = redirect ? {target_raw[31:2], 2'b00} : seq_pc;
            if (misaligned) begin
                err_d = 1'b1;
            end
        end

        // A redirect squashes the wrong-path word currently on im_instr.
        if (flush || (!stall && redirect)) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!stall) begin
            if (range_err) begin
                instr_d = NOP_INSTR;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end else begin
                instr_d = im_instr;
                pc4_d   = seq_pc;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign im_addr    = pc_q;
    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;
    assign addr_err   = err_q;
    assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random control traffic, every
// cycle compared against a rule-level model of the fetch stage.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, br_taken, j_en, jr_en;
    logic [31:0] br_target, jr_target;
    logic [25:0] j_index;
    logic [31:0] im_addr, im_instr, ifid_instr, ifid_pc4, fetch_cnt;
    logic        ifid_valid, addr_err;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [31:0] imem [0:4095];

    // Reference state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_err;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .br_taken(br_taken), .br_target(br_target),
        .j_en(j_en), .j_index(j_index),
        .jr_en(jr_en), .jr_target(jr_target),
        .im_addr(im_addr), .im_instr(im_instr),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .addr_err(addr_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd16384) return imem[a[13:2]];
        return 32'hBAD0_BAD0;
    endfunction

    assign im_instr = mem_word(im_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0; br_taken = 0; j_en = 0; jr_en = 0;
        br_target = 0; jr_target = 0; j_index = 0;
    endtask

    // Advance the model by the architectural rules, then the DUT by one edge, then compare.
    task automatic tick();
        logic        redir;
        logic [31:0] tgt, fetched;
        fetched = mem_word(m_pc);
        if (rst) begin
            m_pc = 32'h3000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_err = 0; m_cnt = 0;
        end else begin
            redir = jr_en || j_en || br_taken;
            if (jr_en)     tgt = jr_target;
            else if (j_en) tgt = {m_pc4[31:28], j_index, 2'b00};
            else           tgt = br_target;
            if (flush) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!stall && redir) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!stall && m_pc > 32'd16380) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0; m_err = 1;
            end else if (!stall) begin
                m_instr = fetched; m_pc4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
            end
            if (!stall) begin
                if (redir) begin
                    if (tgt % 4 != 0) m_err = 1;
                    m_pc = tgt - (tgt % 4);
                end else begin
                    m_pc = m_pc + 4;
                end
            end
        end
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d pc=%h ifid_instr=%h pc4=%h valid=%b err=%b cnt=%0d",
                 txn, im_addr, ifid_instr, ifid_pc4, ifid_valid, addr_err, fetch_cnt);
        check("im_addr", im_addr, m_pc);
        check("ifid_instr", ifid_instr, m_instr);
        check("ifid_pc4", ifid_pc4, m_pc4);
        check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        check("addr_err", 32'(addr_err), 32'(m_err));
        check("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = $urandom;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_err = 0; m_cnt = 0;
        idle();

        // Reset and sequential fetch
        rst = 1; tick();
        check("rst_pc", im_addr, 32'h3000);
        check("rst_valid", 32'(ifid_valid), 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        rst = 0;
        tick(); check("seq1_pc4", ifid_pc4, 32'h3004); check("seq1_valid", 32'(ifid_valid), 32'd1);
        check("seq1_instr", ifid_instr, imem[12'hC00]);
        tick(); check("seq2_pc4", ifid_pc4, 32'h3008);
        tick(); check("seq3_pc", im_addr, 32'h300C); check("seq3_pc4", ifid_pc4, 32'h300C);
        check("seq3_cnt", fetch_cnt, 32'd3);

        // Jump from an instruction whose pc4 is 0x30C0
        jr_en = 1; jr_target = 32'h30BC; tick(); idle();
        tick(); check("pre_j_pc4", ifid_pc4, 32'h30C0);
        j_en = 1; j_index = 26'h0000c08; tick(); idle();
        check("j_pc", im_addr, 32'h3020); check("j_bubble", 32'(ifid_valid), 32'd0);
        tick(); check("j_pc4", ifid_pc4, 32'h3024); check("j_instr", ifid_instr, imem[12'hC08]);

        // Stall at 0x3010 with a branch pulse that must be ignored
        jr_en = 1; jr_target = 32'h3010; tick(); idle();
        tick();
        stall = 1; tick();
        br_taken = 1; br_target = 32'h3200; tick();
        check("stall_pc", im_addr, 32'h3014);
        idle(); tick(); check("resume_pc", im_addr, 32'h3018);

        // Redirect priority, then the same with flush+stall
        jr_en = 1; jr_target = 32'h3100; j_en = 1; j_index = 26'h0000c40;
        br_taken = 1; br_target = 32'h3300; tick();
        check("prio_pc", im_addr, 32'h3100);
        idle(); tick();
        jr_en = 1; jr_target = 32'h3100; j_en = 1; br_taken = 1; flush = 1; stall = 1; tick();
        check("fs_pc", im_addr, 32'h3104); check("fs_valid", 32'(ifid_valid), 32'd0);
        idle();

        // Misaligned and out-of-range targets
        jr_en = 1; jr_target = 32'h3102; tick();
        check("mis_pc", im_addr, 32'h3100); check("mis_err", 32'(addr_err), 32'd1);
        jr_target = 32'h3FFE; tick(); check("edge_pc", im_addr, 32'h3FFC);
        idle(); tick(); check("edge_valid", 32'(ifid_valid), 32'd1); check("edge_pc4", ifid_pc4, 32'h4000);
        jr_en = 1; jr_target = 32'h4000; tick(); idle();
        check("oor_pc", im_addr, 32'h4000);
        tick(); check("oor_valid", 32'(ifid_valid), 32'd0); check("oor_err", 32'(addr_err), 32'd1);

        // Reset during a stall with a redirect pending
        rst = 1; stall = 1; br_taken = 1; br_target = 32'h3500; tick();
        check("rst2_pc", im_addr, 32'h3000); check("rst2_err", 32'(addr_err), 32'd0);
        check("rst2_cnt", fetch_cnt, 32'd0);
        idle();

        // Random control traffic
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 99) < 2);
            stall    = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 10);
            br_taken = ($urandom_range(0, 99) < 10);
            j_en     = ($urandom_range(0, 99) < 6);
            jr_en    = ($urandom_range(0, 99) < 6);
            br_target = $urandom_range(32'h3000, 32'h3FFF) & 32'hFFFF_FFFC;
            jr_target = $urandom_range(32'h3000, 32'h4010);
            if ($urandom_range(0, 9) != 0) jr_target = jr_target & 32'hFFFF_FFFC;
            j_index  = 26'($urandom_range(12'hC00, 12'hFFF));
            tick();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
